alu_share_arbiter: RTL and testbench

Shares one registered 4-bit ALU datapath (add/mul/or/and, 8-bit result) among NUM_REQ requesters. Each requester issues an operation over a valid/ready handshake. A round-robin arbiter grants one request at a time and the block returns a tagged result over a response handshake with backpressure. It sits between multiple client blocks and the single shared arithmetic resource, replacing per-client ALU instances.

---
 rtl/alu_share_arbiter_if.sv | 28 ++
 rtl/alu_share_arbiter.sv | 131 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the client blocks and the shared ALU.
//   master : client side; drives requests (valid, operands, opcode) and rsp_ready
//   slave  : arbiter side; drives per-requester grants and the tagged response
// Requester i occupies req_a/req_b[4i+3:4i] and req_op[2i+1:2i].
interface alu_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [4*NUM_REQ-1:0] req_a;
    logic [4*NUM_REQ-1:0] req_b;
    logic [2*NUM_REQ-1:0] req_op;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [7:0]           rsp_data;
    logic [ID_W-1:0]      rsp_id;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// One registered 4-bit ALU (add/mul/or/and, 8-bit result) shared among
// NUM_REQ requesters under round-robin arbitration.
//   clk  : rising-edge clock
//   rst  : synchronous active-low reset
//   bus  : slave side of alu_share_arbiter_if (request grants, tagged response)
//   busy : high whenever the FSM is not idle
// Flow: IDLE (grant + capture) -> EXEC (compute into rsp regs) -> RESP (hold
// until rsp_ready) -> IDLE. Grants are only issued from IDLE.
module alu_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    alu_share_arbiter_if.slave  bus,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [3:0]      a_q;
    logic [3:0]      b_q;
    logic [1:0]      op_q;
    logic [ID_W-1:0] id_q;
    logic            rsp_valid_q;
    logic [7:0]      rsp_data_q;
    logic [ID_W-1:0] rsp_id_q;

    logic [NUM_REQ-1:0] grant;
    logic               found;
    logic [ID_W-1:0]    gnt_id;
    logic [ID_W-1:0]    nxt_ptr;
    logic [3:0]         sel_a;
    logic [3:0]         sel_b;
    logic [1:0]         sel_op;

    function automatic logic [7:0] alu_result(input logic [3:0] a,
                                              input logic [3:0] b,
                                              input logic [1:0] op);
        logic [7:0] r;
        case (op)
            2'd0:    r = {4'd0, a} + {4'd0, b};
            2'd1:    r = {4'd0, a} * {4'd0, b};
            2'd2:    r = {4'd0, a | b};
            default: r = {4'd0, a & b};
        endcase
        return r;
    endfunction

    // Round-robin search starting at rr_ptr; the first valid requester wins.
    // Only evaluated in IDLE so req_ready stays low in EXEC/RESP.
    always_comb begin
        int idx;
        grant   = '0;
        found   = 1'b0;
        gnt_id  = '0;
        nxt_ptr = rr_ptr;
        sel_a   = '0;
        sel_b   = '0;
        sel_op  = '0;
        idx     = 0;
        if (state == IDLE) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (int'(rr_ptr) + k) % NUM_REQ;
                if (!found && bus.req_valid[idx]) begin
                    found       = 1'b1;
                    grant[idx]  = 1'b1;
                    gnt_id      = ID_W'(idx);
                    nxt_ptr     = ID_W'((idx + 1) % NUM_REQ);
                    sel_a       = bus.req_a[idx*4 +: 4];
                    sel_b       = bus.req_b[idx*4 +: 4];
                    sel_op      = bus.req_op[idx*2 +: 2];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        a_q    <= sel_a;
                        b_q    <= sel_b;
                        op_q   <= sel_op;
                        id_q   <= gnt_id;
                        rr_ptr <= nxt_ptr;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_q  <= alu_result(a_q, b_q, op_q);
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    // Data/id are left untouched on completion; only valid drops.
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

    logic clk;
    logic rst;
    logic busy;

    int n_checks = 0;
    int n_pass   = 0;

    alu_share_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus ();

    alu_share_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int id, input logic [3:0] a,
                            input logic [3:0] b, input logic [1:0] op);
        bus.req_a[id*4 +: 4] = a;
        bus.req_b[id*4 +: 4] = b;
        bus.req_op[id*2 +: 2] = op;
    endtask

    function automatic int onehot_idx(input logic [3:0] v);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Single request from one requester: grant, EXEC, RESP, accept.
    task automatic do_txn(input string tag, input int id, input logic [3:0] a,
                          input logic [3:0] b, input logic [1:0] op,
                          input logic [7:0] exp);
        logic [3:0] want;
        want = 4'b0001 << id;
        set_lane(id, a, b, op);
        bus.req_valid = want;
        #1;
        check({tag, "_grant"}, int'(bus.req_ready), int'(want));
        step();
        bus.req_valid = '0;
        check({tag, "_exec_busy"}, int'(busy), 1);
        check({tag, "_exec_novalid"}, int'(bus.rsp_valid), 0);
        step();
        check({tag, "_rsp_valid"}, int'(bus.rsp_valid), 1);
        check({tag, "_rsp_data"}, int'(bus.rsp_data), int'(exp));
        check({tag, "_rsp_id"}, int'(bus.rsp_id), id);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check({tag, "_done_valid"}, int'(bus.rsp_valid), 0);
        check({tag, "_done_busy"}, int'(busy), 0);
        check({tag, "_data_kept"}, int'(bus.rsp_data), int'(exp));
    endtask

    initial begin
        int order[5];
        int ng;
        int last_c;
        int pend;
        int g;

        vecs[0] = '{0, 4'hF, 4'hF, 2'd0, 8'h1E};
        vecs[1] = '{2, 4'hF, 4'hF, 2'd1, 8'hE1};
        vecs[2] = '{1, 4'hA, 4'h5, 2'd2, 8'h0F};
        vecs[3] = '{1, 4'hC, 4'hA, 2'd3, 8'h08};
        vecs[4] = '{3, 4'h7, 4'h9, 2'd0, 8'h10};
        vecs[5] = '{0, 4'h0, 4'h0, 2'd1, 8'h00};
        vecs[6] = '{3, 4'hF, 4'h0, 2'd2, 8'h0F};
        vecs[7] = '{2, 4'h9, 4'h6, 2'd3, 8'h00};
        order   = '{0, 1, 2, 3, 0};

        rst = 1'b0;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_op = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) step();
        check("rst_rsp_valid", int'(bus.rsp_valid), 0);
        check("rst_rsp_data", int'(bus.rsp_data), 0);
        check("rst_rsp_id", int'(bus.rsp_id), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b1;
        step();
        check("idle_no_req", int'(bus.req_ready), 0);

        for (int i = 0; i < 8; i++)
            do_txn($sformatf("vec%0d", i), vecs[i].id, vecs[i].a, vecs[i].b,
                   vecs[i].op, vecs[i].exp);

        // Round robin with everyone requesting continuously.
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) set_lane(i, 4'(i + 1), 4'd2, 2'd0);
        bus.req_valid = 4'hF;
        bus.rsp_ready = 1'b1;
        ng = 0;
        last_c = 0;
        pend = -1;
        #1;
        for (int c = 0; c < 20 && ng < 5; c++) begin
            if (bus.rsp_valid) begin
                check("rr_rsp_id", int'(bus.rsp_id), pend);
                check("rr_rsp_data", int'(bus.rsp_data), pend + 3);
            end
            if (bus.req_ready != 0) begin
                g = onehot_idx(bus.req_ready);
                check("rr_order", g, order[ng]);
                if (ng > 0) check("rr_spacing", c - last_c, 3);
                last_c = c;
                pend = g;
                ng++;
            end
            step();
        end
        check("rr_grant_count", ng, 5);
        bus.req_valid = '0;
        repeat (3) step();
        bus.rsp_ready = 1'b0;
        check("rr_drain_idle", int'(busy), 0);

        // Backpressure on req1 while req3 waits.
        set_lane(1, 4'h6, 4'h7, 2'd1);
        set_lane(3, 4'h3, 4'h5, 2'd0);
        bus.req_valid = 4'b0010;
        #1;
        check("bp_grant", int'(bus.req_ready), 2);
        step();
        bus.req_valid = 4'b1000;
        check("bp_exec_ready", int'(bus.req_ready), 0);
        step();
        for (int c = 0; c < 5; c++) begin
            check("bp_hold_valid", int'(bus.rsp_valid), 1);
            check("bp_hold_data", int'(bus.rsp_data), 42);
            check("bp_hold_id", int'(bus.rsp_id), 1);
            check("bp_hold_ready", int'(bus.req_ready), 0);
            step();
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check("bp_done_valid", int'(bus.rsp_valid), 0);
        check("bp_next_grant", int'(bus.req_ready), 8);
        step();
        bus.req_valid = '0;
        step();
        check("bp_req3_valid", int'(bus.rsp_valid), 1);
        check("bp_req3_id", int'(bus.rsp_id), 3);
        check("bp_req3_data", int'(bus.rsp_data), 8);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;

        // Reset during EXEC: after req1 the pointer would be 2, reset makes it 0.
        set_lane(1, 4'h2, 4'h2, 2'd0);
        bus.req_valid = 4'b0010;
        #1;
        check("rx_grant", int'(bus.req_ready), 2);
        step();
        bus.req_valid = '0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("rx_valid", int'(bus.rsp_valid), 0);
        check("rx_busy", int'(busy), 0);
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check("rx_no_rsp", int'(bus.rsp_valid), 0);
            step();
        end
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0101;
        #1;
        check("rx_ptr_zero", int'(bus.req_ready), 1);
        bus.req_valid = '0;
        #1;
        do_txn("rx_req3", 3, 4'h5, 4'h3, 2'd1, 8'h0F);

        // After req1 is granted, req0 and req2 pending: req2 first, then req0.
        do_txn("rp_req1", 1, 4'h1, 4'h1, 2'd0, 8'h02);
        set_lane(0, 4'h3, 4'h4, 2'd1);
        set_lane(2, 4'h3, 4'h4, 2'd1);
        bus.req_valid = 4'b0101;
        #1;
        check("rp_first", int'(bus.req_ready), 4);
        step();
        step();
        check("rp_first_id", int'(bus.rsp_id), 2);
        check("rp_first_data", int'(bus.rsp_data), 12);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check("rp_second", int'(bus.req_ready), 1);
        step();
        bus.req_valid = '0;
        step();
        check("rp_second_id", int'(bus.rsp_id), 0);
        check("rp_second_data", int'(bus.rsp_data), 12);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
